// File: rtl/vga_timing_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : vga_timing_if                                         |
// | Purpose  : Pixel strobe, colour request/return and VGA pin bus   |
// |            between the raster timing generator and its users.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface vga_timing_if;
  logic       pix_en;
  logic [5:0] color_in;
  logic [9:0] colPos;
  logic [9:0] rowPos;
  logic       on;
  logic       hsync;
  logic       vsync;
  logic [1:0] vga_r;
  logic [1:0] vga_g;
  logic [1:0] vga_b;
  logic       frame_start;

  // Timing generator side: consumes strobe and colour, drives position and pins.
  modport master (
    input  pix_en, color_in,
    output colPos, rowPos, on, hsync, vsync, vga_r, vga_g, vga_b, frame_start
  );

  // Compositor / board side: supplies strobe and colour, observes the rest.
  modport slave (
    output pix_en, color_in,
    input  colPos, rowPos, on, hsync, vsync, vga_r, vga_g, vga_b, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : vga_timing                                            |
// | Purpose  : 640x480@60 raster counter with a one-stage registered |
// |            colour/sync output so pins stay mutually aligned.     |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module vga_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    reset,
  vga_timing_if.master bus
);

  localparam int        c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int        c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_H_LAST  = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST  = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [5:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_on;
  logic       w_hs_zone;
  logic       w_vs_zone;

  assign w_h_last  = (r_h_cnt == c_H_LAST);
  assign w_v_last  = (r_v_cnt == c_V_LAST);
  // reset forces blanking so the compositor never sees a visible pixel mid-reset
  assign w_on      = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT) && !reset;
  assign w_hs_zone = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
  assign w_vs_zone = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);

  // Raster counters: horizontal wraps each line, vertical steps on that wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (bus.pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Output stage: colour and both syncs share one pixel of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= ~SYNC_ACTIVE;
      r_vsync <= ~SYNC_ACTIVE;
    end else if (bus.pix_en) begin
      r_rgb   <= w_on ? bus.color_in : 6'b000000;
      r_hsync <= w_hs_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync <= w_vs_zone ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign bus.colPos      = r_h_cnt;
  assign bus.rowPos      = r_v_cnt;
  assign bus.on          = w_on;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.vga_r       = r_rgb[5:4];
  assign bus.vga_g       = r_rgb[3:2];
  assign bus.vga_b       = r_rgb[1:0];
  assign bus.frame_start = bus.pix_en && w_h_last && w_v_last && !reset;

endmodule
`default_nettype wire
